led_cmd_scheduler: RTL and testbench

LED_CMD_SCHEDULER -- requirements
Module: led_cmd_scheduler

---
 rtl/led_cmd_pkg.sv | 37 +++
 rtl/led_blink_engine.sv | 38 +++
 rtl/led_cmd_scheduler.sv | 122 ++++++++++++
 tb/tb_led_cmd_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_cmd_pkg.sv
// Shared types and ASCII command constants for the LED command scheduler.
package led_cmd_pkg;

    typedef enum logic [1:0] {IDLE, GET_IDX, GET_RATE, APPLY} state_t;

    typedef enum logic [1:0] {OP_NONE, OP_TOGGLE, OP_CLEAR, OP_RATE} op_t;

    typedef struct packed {
        op_t        op;
        logic [1:0] idx;
        logic [2:0] rate;
    } cmd_t;

    localparam int RATE_BASE_DEF = 16;

    localparam logic [7:0] CH_LED1  = 8'h31;
    localparam logic [7:0] CH_LED4  = 8'h34;
    localparam logic [7:0] CH_CLEAR = 8'h43;
    localparam logic [7:0] CH_RATE  = 8'h52;
    localparam logic [7:0] CH_RATE0 = 8'h30;
    localparam logic [7:0] CH_RATE7 = 8'h37;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    function automatic logic is_led_char(input logic [7:0] b);
        return (b >= CH_LED1) && (b <= CH_LED4);
    endfunction

    function automatic logic is_rate_char(input logic [7:0] b);
        return (b >= CH_RATE0) && (b <= CH_RATE7);
    endfunction

    function automatic logic [1:0] led_idx(input logic [7:0] b);
        return 2'(b - CH_LED1);
    endfunction

endpackage

// File: rtl/led_blink_engine.sv
// Free-running tick counter and per-LED blink mux with registered outputs.
module led_blink_engine
    import led_cmd_pkg::*;
#(
    parameter int NUM_LEDS  = 4,
    parameter int RATE_BASE = RATE_BASE_DEF
) (
    input  logic                     hwclk,
    input  logic                     rst_n,
    input  logic [NUM_LEDS-1:0]      i_enable,
    input  logic [NUM_LEDS-1:0][2:0] i_rate,
    output logic [NUM_LEDS-1:0]      o_led
);

    logic [31:0]         r_tick;
    logic [NUM_LEDS-1:0] r_led;
    logic [NUM_LEDS-1:0] w_on;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) r_tick <= '0;
        else        r_tick <= r_tick + 32'd1;
    end

    // Rate 0 is steady-on; rate k follows tick bit RATE_BASE+k.
    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_lane
        logic [31:0] w_shift;
        assign w_shift = r_tick >> (RATE_BASE + int'(i_rate[g]));
        assign w_on[g] = i_enable[g] & ((i_rate[g] == 3'd0) | w_shift[0]);
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) r_led <= '0;
        else        r_led <= w_on;
    end

    assign o_led = r_led;

endmodule

// File: rtl/led_cmd_scheduler.sv
// UART byte command parser driving LED enable/rate config into the blink engine.
module led_cmd_scheduler
    import led_cmd_pkg::*;
#(
    parameter int NUM_LEDS  = 4,
    parameter int RATE_BASE = RATE_BASE_DEF
) (
    input  logic                hwclk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [NUM_LEDS-1:0] led,
    output logic [7:0]          err_cnt
);

    state_t                   r_state, w_state_nxt;
    cmd_t                     r_cmd, w_cmd_nxt;
    logic                     w_accept, w_err;
    logic [NUM_LEDS-1:0]      r_enable;
    logic [NUM_LEDS-1:0][2:0] r_rate;
    logic [7:0]               r_err_cnt;

    assign rx_ready = (r_state != APPLY);
    assign w_accept = rx_valid && rx_ready;
    assign err_cnt  = r_err_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_err       = 1'b0;
        case (r_state)
            IDLE: if (w_accept) begin
                if (is_led_char(rx_data)) begin
                    w_cmd_nxt   = '{op: OP_TOGGLE, idx: led_idx(rx_data), rate: 3'd0};
                    w_state_nxt = APPLY;
                end else if (rx_data == CH_CLEAR) begin
                    w_cmd_nxt   = '{op: OP_CLEAR, idx: 2'd0, rate: 3'd0};
                    w_state_nxt = APPLY;
                end else if (rx_data == CH_RATE) begin
                    w_state_nxt = GET_IDX;
                end else if (rx_data != CH_CR && rx_data != CH_LF) begin
                    w_err = 1'b1;
                end
            end
            GET_IDX: if (w_accept) begin
                if (is_led_char(rx_data)) begin
                    w_cmd_nxt.op  = OP_RATE;
                    w_cmd_nxt.idx = led_idx(rx_data);
                    w_state_nxt   = GET_RATE;
                end else begin
                    w_err       = 1'b1;
                    w_cmd_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            GET_RATE: if (w_accept) begin
                if (is_rate_char(rx_data)) begin
                    w_cmd_nxt.rate = rx_data[2:0];
                    w_state_nxt    = APPLY;
                end else begin
                    w_err       = 1'b1;
                    w_cmd_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            APPLY: begin
                w_cmd_nxt   = '0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cmd     <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // Config is written only on the edge that ends APPLY.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable <= '0;
            r_rate   <= '0;
        end else if (r_state == APPLY) begin
            case (r_cmd.op)
                OP_CLEAR: begin
                    r_enable <= '0;
                    r_rate   <= '0;
                end
                OP_TOGGLE, OP_RATE: begin
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        if (int'(r_cmd.idx) == i) begin
                            if (r_cmd.op == OP_TOGGLE) r_enable[i] <= ~r_enable[i];
                            else                       r_rate[i]   <= r_cmd.rate;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    led_blink_engine #(
        .NUM_LEDS  (NUM_LEDS),
        .RATE_BASE (RATE_BASE)
    ) u_engine (
        .hwclk    (hwclk),
        .rst_n    (rst_n),
        .i_enable (r_enable),
        .i_rate   (r_rate),
        .o_led    (led)
    );

endmodule

// File: tb/tb_led_cmd_scheduler.sv
// Randomized and directed bench for led_cmd_scheduler against a byte-level command model.
module tb_led_cmd_scheduler;
    import led_cmd_pkg::*;

    localparam int RB = 4;

    logic       hwclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [3:0] led;
    logic [7:0] err_cnt;

    int n_chk = 0;
    int n_fail = 0;

    int m_en[4];
    int m_rate[4];
    int m_err;
    int m_phase;
    int m_idx;
    int unsigned tick_m;

    led_cmd_scheduler #(.NUM_LEDS(4), .RATE_BASE(RB)) dut (
        .hwclk    (hwclk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .led      (led),
        .err_cnt  (err_cnt)
    );

    always #5 hwclk = ~hwclk;

    // Cycles since reset release: what the free-running tick should hold.
    always @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) tick_m <= 0;
        else        tick_m <= tick_m + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) begin
            m_en[i] = 0;
            m_rate[i] = 0;
        end
        m_err = 0;
        m_phase = 0;
        m_idx = 0;
    endfunction

    function automatic void m_bump();
        if (m_err < 255) m_err++;
    endfunction

    function automatic void m_apply(input logic [7:0] b);
        int v;
        v = int'(b);
        case (m_phase)
            0: begin
                if (v >= 'h31 && v <= 'h34) m_en[v - 'h31] = (m_en[v - 'h31] == 0) ? 1 : 0;
                else if (v == 'h43) begin
                    for (int i = 0; i < 4; i++) begin
                        m_en[i] = 0;
                        m_rate[i] = 0;
                    end
                end
                else if (v == 'h52) m_phase = 1;
                else if (v != 'h0D && v != 'h0A) m_bump();
            end
            1: begin
                if (v >= 'h31 && v <= 'h34) begin
                    m_idx = v - 'h31;
                    m_phase = 2;
                end else begin
                    m_bump();
                    m_phase = 0;
                end
            end
            default: begin
                if (v >= 'h30 && v <= 'h37) m_rate[m_idx] = v - 'h30;
                else m_bump();
                m_phase = 0;
            end
        endcase
    endfunction

    function automatic logic [3:0] m_en_vec();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m_en[i] != 0);
        return r;
    endfunction

    function automatic logic [3:0] exp_led();
        logic [3:0] r;
        int unsigned t;
        t = tick_m - 1;
        for (int i = 0; i < 4; i++)
            r[i] = (m_en[i] != 0) && (m_rate[i] == 0 || ((t >> (RB + m_rate[i])) & 1) != 0);
        return r;
    endfunction

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge hwclk);
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            @(negedge hwclk);
            n++;
        end
        if (n >= 20) chk("rdy_timeout", rx_ready, 1);
        @(posedge hwclk);
        #1 rx_valid = 1'b0;
        m_apply(b);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_err"}, err_cnt, m_err);
        chk({tag, "_en"}, dut.r_enable, m_en_vec());
        for (int i = 0; i < 4; i++) chk({tag, "_rate"}, dut.r_rate[i], m_rate[i]);
        chk({tag, "_led"}, led, exp_led());
    endtask

    task automatic do_reset();
        @(negedge hwclk);
        rst_n = 1'b0;
        @(negedge hwclk);
        rst_n = 1'b1;
        m_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        logic [7:0]  b;
        logic [31:0] t0;
        int          n;
        m_reset();

        #12;
        chk("rst_ready", rx_ready, 1);
        chk("rst_led", led, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_en", dut.r_enable, 0);
        chk("rst_tick", dut.u_engine.r_tick, 0);
        chk("rst_state", dut.r_state, IDLE);
        @(negedge hwclk);
        rst_n = 1'b1;

        // '1': one-cycle busy, enable at E1, led at E2
        send(8'h31);
        @(negedge hwclk);
        chk("t1_busy", rx_ready, 0);
        chk("t1_led_e0", led[0], 0);
        @(negedge hwclk);
        chk("t1_ready_back", rx_ready, 1);
        chk("t1_en", dut.r_enable, 4'b0001);
        chk("t1_led_e1", led[0], 0);
        @(negedge hwclk);
        chk("t1_led_e2", led[0], 1);

        send(8'h52); send(8'h32); send(8'h33);
        repeat (3) @(negedge hwclk);
        chk("r23_rate1", dut.r_rate[1], 3);
        chk("r23_en", dut.r_enable, 4'b0001);
        send(8'h32);
        repeat (3) @(negedge hwclk);
        for (int k = 0; k < 300; k++) begin
            chk("blink_led1", led[1], ((tick_m - 1) >> (RB + 3)) & 1);
            chk("blink_led0", led[0], 1);
            @(negedge hwclk);
        end

        send(8'h58); send(8'h52); send(8'h39);
        repeat (2) @(negedge hwclk);
        chk("bad_err2", err_cnt, 2);
        chk("bad_state", dut.r_state, IDLE);
        check_all("bad_cfg");
        for (int k = 0; k < 300; k++) send(8'h58);
        repeat (2) @(negedge hwclk);
        chk("sat_err", err_cnt, 255);
        chk("sat_model", err_cnt, m_err);

        send(8'h33); send(8'h34);
        send(8'h52); send(8'h31); send(8'h35);
        send(8'h52); send(8'h34); send(8'h37);
        repeat (3) @(negedge hwclk);
        check_all("pre_clr");
        send(8'h43);
        @(negedge hwclk);
        chk("clr_busy", rx_ready, 0);
        @(negedge hwclk);
        chk("clr_en", dut.r_enable, 0);
        chk("clr_rates", dut.r_rate, 0);
        @(negedge hwclk);
        chk("clr_led_e2", led, 0);

        do_reset();
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 9: b = 8'h31 + 8'($urandom_range(0, 3));
                3:          b = ($urandom_range(0, 2) == 0) ? 8'h43 : 8'h31 + 8'($urandom_range(0, 3));
                4, 5:       b = 8'h52;
                6:          b = 8'h30 + 8'($urandom_range(0, 7));
                7:          b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
                default:    b = 8'($urandom_range(0, 255));
            endcase
            send(b);
            repeat (3) @(negedge hwclk);
            check_all("rnd");
        end

        // reset in GET_RATE discards the command and any byte offered during reset
        do_reset();
        send(8'h52); send(8'h33); send(8'h35);
        repeat (3) @(negedge hwclk);
        chk("pre_rst_rate2", dut.r_rate[2], 5);
        send(8'h52); send(8'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state", dut.r_state, IDLE);
        chk("midrst_rate2", dut.r_rate[2], 0);
        chk("midrst_led", led, 0);
        chk("midrst_err", err_cnt, 0);
        rx_data = 8'h31;
        rx_valid = 1'b1;
        repeat (2) @(negedge hwclk);
        chk("inrst_ready", rx_ready, 1);
        chk("inrst_en", dut.r_enable, 0);
        rx_valid = 1'b0;
        rst_n = 1'b1;
        m_reset();
        send(8'h33);
        repeat (3) @(negedge hwclk);
        chk("postrst_en", dut.r_enable, 4'b0100);
        check_all("postrst");

        // tick wrap with LED1 steady-on
        send(8'h31);
        repeat (3) @(negedge hwclk);
        chk("wrap_pre_led", led, 4'b0101);
        force dut.u_engine.r_tick = 32'hFFFF_FFF0;
        @(negedge hwclk);
        release dut.u_engine.r_tick;
        t0 = dut.u_engine.r_tick;
        chk("wrap_forced", (t0 >= 32'hFFFF_FFF0) && (t0 <= 32'hFFFF_FFF2), 1);
        n = int'(33'h1_0000_0000 - {1'b0, t0});
        repeat (n) begin
            @(negedge hwclk);
            chk("wrap_led0", led[0], 1);
        end
        chk("wrap_tick0", dut.u_engine.r_tick, 0);
        repeat (3) begin
            @(negedge hwclk);
            chk("wrap_led0_after", led[0], 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
